// File: rtl/clk_sw_pkg.sv
// Shared definitions for the clock-switch controller: FSM states,
// default timing constants and the counter-width helper.
package clk_sw_pkg;

    // Default cycles sel is held stable after a change before done is reported.
    localparam int SETTLE_CYC_DEF  = 16;
    // Default cycles spent waiting for the target clock's ok flag.
    localparam int TIMEOUT_CYC_DEF = 1024;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        SWITCH = 2'd2,
        SETTLE = 2'd3
    } state_t;

    // Width of the shared settle/timeout counter: enough bits to hold
    // (larger of the two cycle counts) - 1, which is the highest value
    // the FSM ever compares against.
    function automatic int cnt_width(input int settle_cyc, input int timeout_cyc);
        int larger;
        larger = (settle_cyc > timeout_cyc) ? settle_cyc : timeout_cyc;
        return $clog2(larger);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// The output is taken straight from the second flop.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back capture flops; both clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_switch_ctrl.sv
// Clock-switch controller. Accepts a request for clk0 or clk1, waits for
// the target clock's synchronized ok flag (bounded by a timeout), flips
// the registered select for the downstream glitch-free mux, then holds it
// stable for a settle period before reporting completion.
//
// Handshake: a request transfers on a rising clk edge where
// req_valid && req_ready. req_ready is high only in IDLE; req_valid seen
// in any other state is dropped, never queued. Each accepted request
// produces at most one one-cycle pulse, done (success or no-op) or err
// (timeout), never both.
module clk_switch_ctrl
    import clk_sw_pkg::*;
#(
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    input  logic clk0_ok_async,
    input  logic clk1_ok_async,
    output logic sel,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int CW = cnt_width(SETTLE_CYC, TIMEOUT_CYC);

    // Last counter values in CHECK and SETTLE before leaving the state.
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX      = '1;

    // Registered state.
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          target_q;
    logic          sel_q;
    logic          done_q;
    logic          err_q;

    // Next-state values.
    state_t        state_d;
    logic [CW-1:0] cnt_d;
    logic          target_d;
    logic          sel_d;
    logic          done_d;
    logic          err_d;

    // Synchronized ok flags; the FSM looks at nothing else.
    logic clk0_ok;
    logic clk1_ok;
    logic target_ok;
    logic accept;

    sync_2ff u_sync_clk0 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (clk0_ok_async),
        .q     (clk0_ok)
    );

    sync_2ff u_sync_clk1 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (clk1_ok_async),
        .q     (clk1_ok)
    );

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign accept    = req_valid && req_ready;
    assign target_ok = target_q ? clk1_ok : clk0_ok;

    // Outputs come straight from flops.
    assign sel  = sel_q;
    assign done = done_q;
    assign err  = err_q;

    // State, counter, select and pulse registers; reset aborts everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= 1'b0;
            sel_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            sel_q    <= sel_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state and pulse logic. The counter saturates at all-ones
    // instead of wrapping, although the compares below leave before that.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        sel_d    = sel_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_sel == sel_q) begin
                        // Already on the requested source: report at once.
                        done_d = 1'b1;
                    end else begin
                        target_d = req_sel;
                        cnt_d    = '0;
                        state_d  = CHECK;
                    end
                end
            end

            CHECK: begin
                // A running target wins even on the last allowed cycle.
                if (target_ok) begin
                    state_d = SWITCH;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            SWITCH: begin
                // The only place sel is ever loaded outside reset.
                sel_d   = target_q;
                cnt_d   = '0;
                state_d = SETTLE;
            end

            SETTLE: begin
                // ok dropping here is deliberately not watched.
                if (cnt_q == SETTLE_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Self-checking bench for clk_switch_ctrl: directed scenarios followed by
// randomized traffic, every cycle compared against an edge-timeline model.
module tb_clk_switch_ctrl;

  localparam int S = 16;
  localparam int T = 1024;

  logic clk;
  logic rst_n;
  logic req_valid;
  logic req_sel;
  logic req_ready;
  logic clk0_ok_async;
  logic clk1_ok_async;
  logic sel;
  logic busy;
  logic done;
  logic err;

  clk_switch_ctrl #(
    .SETTLE_CYC  (S),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_sel       (req_sel),
    .req_ready     (req_ready),
    .clk0_ok_async (clk0_ok_async),
    .clk1_ok_async (clk1_ok_async),
    .sel           (sel),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total;
  int bad;
  int cyc;          // index of the most recent (or upcoming) rising edge
  int first_edge;   // first edge after reset release
  bit hist0 [0:65535];
  bit hist1 [0:65535];
  bit cur0;
  bit cur1;

  // Reference model: a request is a timeline of edges, not a state machine.
  bit m_busy;
  bit m_sel;
  bit m_target;
  int m_acc;        // edge the request was accepted on
  int m_sw;         // edge sel is loaded on, -1 while still waiting for ok
  bit exp_done;
  bit exp_err;
  logic [0:0] exp_q[$];  // expected pulse history, one entry per done/err

  int done_cnt;
  int err_cnt;
  int last_done_cyc;
  int last_err_cyc;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s at edge %0d: got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // ok as the controller sees it on edge n: the level present two edges
  // earlier, and nothing from before the reset release.
  function automatic bit seen(input bit t, input int n);
    int idx;
    idx = n - 2;
    if (idx < first_edge || idx < 0) return 1'b0;
    return t ? hist1[idx] : hist0[idx];
  endfunction

  task automatic model_edge(input int n, input bit rv, input bit rs);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (!m_busy) begin
      if (rv) begin
        if (rs == m_sel) begin
          exp_done = 1'b1;
        end else begin
          m_busy   = 1'b1;
          m_target = rs;
          m_acc    = n;
          m_sw     = -1;
        end
      end
    end else if (m_sw < 0) begin
      if (seen(m_target, n)) m_sw = n + 1;
      else if (n == m_acc + T) begin
        exp_err = 1'b1;
        m_busy  = 1'b0;
      end
    end else if (n == m_sw) begin
      m_sel = m_target;
    end else if (n == m_sw + S) begin
      exp_done = 1'b1;
      m_busy   = 1'b0;
    end
    if (exp_done || exp_err) exp_q.push_back(exp_done);
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_sel    = 1'b0;
    m_target = 1'b0;
    m_sw     = -1;
    exp_done = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic check_outputs();
    check("sel", sel, m_sel);
    check("busy", busy, m_busy);
    check("req_ready", req_ready, !m_busy);
    check("done", done, exp_done);
    check("err", err, exp_err);
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit rv, input bit rs);
    @(negedge clk);
    check_outputs();
    req_valid     = rv;
    req_sel       = rs;
    clk0_ok_async = cur0;
    clk1_ok_async = cur1;
    cyc++;
    hist0[cyc] = cur0;
    hist1[cyc] = cur1;
    model_edge(cyc, rv, rs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    model_reset();
    #1;
    check_outputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cyc++;
      check_outputs();
    end
    rst_n         = 1'b1;
    clk0_ok_async = cur0;
    clk1_ok_async = cur1;
    cyc++;
    first_edge = cyc;
    hist0[cyc] = cur0;
    hist1[cyc] = cur1;
    model_edge(cyc, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  int acc;
  int rise;
  int d0;
  int e0;

  initial begin
    total = 0; bad = 0; cyc = 0; first_edge = 1 << 30;
    done_cnt = 0; err_cnt = 0; last_done_cyc = -1; last_err_cyc = -1;
    rst_n = 1'b0; req_valid = 1'b0; req_sel = 1'b0;
    clk0_ok_async = 1'b0; clk1_ok_async = 1'b0;
    cur0 = 1'b0; cur1 = 1'b0;
    model_reset();
    do_reset();

    // Switch to clk1 with its ok already synchronized high.
    cur0 = 1'b1; cur1 = 1'b1;
    idle(4);
    acc = cyc + 1;
    d0  = done_cnt;
    step(1'b1, 1'b1);
    idle(24);
    check("s1_done_count", done_cnt - d0, 1);
    check("s1_done_latency", last_done_cyc - acc, S + 2);
    check("s1_sel", sel, 1);

    // Request the source already selected: immediate done, no busy.
    d0  = done_cnt;
    step(1'b1, 1'b1);
    acc = cyc;
    idle(3);
    check("s2_done_count", done_cnt - d0, 1);
    check("s2_done_latency", last_done_cyc - acc, 0);
    check("s2_sel", sel, 1);

    // Target never comes up: timeout after T CHECK cycles.
    cur1 = 1'b0;
    do_reset();
    idle(4);
    acc = cyc + 1;
    e0  = err_cnt;
    d0  = done_cnt;
    step(1'b1, 1'b1);
    idle(T + 5);
    check("s3_err_count", err_cnt - e0, 1);
    check("s3_err_latency", last_err_cyc - acc, T);
    check("s3_no_done", done_cnt - d0, 0);
    check("s3_sel", sel, 0);
    check("s3_ready", req_ready, 1);

    // Target ok rises 50 cycles into CHECK.
    d0 = done_cnt;
    step(1'b1, 1'b1);
    idle(50);
    cur1 = 1'b1;
    rise = cyc + 1;
    idle(30);
    check("s4_done_count", done_cnt - d0, 1);
    check("s4_done_latency", last_done_cyc - rise, S + 3);
    check("s4_sel", sel, 1);

    // req_valid toggling during SETTLE is ignored.
    d0  = done_cnt;
    step(1'b1, 1'b0);
    idle(5);
    for (int i = 0; i < 8; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle(20);
    check("s5_done_count", done_cnt - d0, 1);
    check("s5_sel", sel, 0);

    // Reset mid-SETTLE aborts silently; next request completes.
    d0 = done_cnt;
    step(1'b1, 1'b1);
    idle(8);
    do_reset();
    check("s6_sel_after_reset", sel, 0);
    idle(4);
    check("s6_no_done", done_cnt - d0, 0);
    step(1'b1, 1'b1);
    idle(24);
    check("s6_done_count", done_cnt - d0, 1);
    check("s6_sel", sel, 1);

    // Randomized traffic with wandering ok flags and rare resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      if ($urandom_range(0, 63) == 0) cur0 = ~cur0;
      if ($urandom_range(0, 63) == 0) cur1 = ~cur1;
      step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end
    idle(2);
    check("pulse_total", done_cnt + err_cnt, exp_q.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_switch_ctrl.md
CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 16: cycles `sel` is held stable after a change before completion is reported (legal 2..255).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1024: maximum cycles spent waiting for the target clock's ok flag (legal 2..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: single always-on control clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: switch request strobe.
REQ-006 The block SHALL have port req_sel, input, 1 bit: requested source (0 = clk0, 1 = clk1).
REQ-007 The block SHALL have port req_ready, output, 1 bit: high only in IDLE.
REQ-008 The block SHALL have port clk0_ok_async, input, 1 bit: clk0 running/locked, asynchronous to clk.
REQ-009 The block SHALL have port clk1_ok_async, input, 1 bit: clk1 running/locked, asynchronous to clk.
REQ-010 The block SHALL have port sel, output, 1 bit: registered select driving the downstream glitch-free clock mux.
REQ-011 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse on successful completion or no-op.
REQ-013 The block SHALL have port err, output, 1 bit: one-cycle pulse on timeout.

Function
REQ-014 The block SHALL pass each clkN_ok_async through its own 2-flop synchronizer before use; the FSM SHALL see only the synchronized values.
REQ-015 The FSM SHALL have states IDLE, CHECK, SWITCH, SETTLE.
- Request acceptance: req_valid && req_ready.
- req_valid outside IDLE: ignored, not queued.
REQ-016 On acceptance in IDLE, if req_sel == sel, the block SHALL pulse done on the next cycle and remain in IDLE (no-op).
REQ-017 On acceptance in IDLE, if req_sel != sel, the block SHALL latch target = req_sel, clear the counter, and go to CHECK.
REQ-018 In CHECK, if the synchronized ok of target is 1, the block SHALL go to SWITCH.
- Otherwise the counter increments.
- When the counter reaches TIMEOUT_CYC-1 with ok still 0: pulse err, return to IDLE, leave sel unchanged.
REQ-019 In SWITCH, for exactly one cycle, the block SHALL load sel <= target, clear the counter, and go to SETTLE.
REQ-020 In SETTLE, the block SHALL count SETTLE_CYC cycles, then pulse done and return to IDLE.
- Loss of ok during SETTLE: ignored, no abort.
REQ-021 Latency, with the target ok already synchronized high and acceptance at edge t0:
- CHECK at t0.
- SWITCH at t1.
- sel toggles at edge t2.
- done is high for the single cycle following edge t2+SETTLE_CYC.
REQ-022 done and err SHALL never be high in the same cycle, and at most one SHALL pulse per accepted request.
REQ-023 The counter SHALL be $clog2 of the larger of SETTLE_CYC and TIMEOUT_CYC bits wide and SHALL saturate rather than wrap.
REQ-024 sel SHALL change at most once per accepted request and only on the SWITCH edge.

Reset
REQ-025 While rst_n is low, the block SHALL drive: state IDLE, sel 0, busy 0, done 0, err 0, counter 0, synchronizer flops 0.
REQ-026 Reset asserted mid-operation SHALL abort immediately with no done or err pulse; sel returns to 0.
REQ-027 After rst_n deasserts, the first request SHALL be accepted no earlier than the first rising clk edge.

Structure
REQ-028 The state enum, the default SETTLE_CYC and TIMEOUT_CYC constants, and the counter-width function SHALL reside in the shared package clk_sw_pkg.
REQ-029 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, instantiated twice.
REQ-030 sel SHALL be driven directly from a flop, with no combinational logic on the output.

Verification
REQ-031 The bench SHALL cover each of the following directed scenarios:
- Reset, then clk1_ok high, then request req_sel=1 -> sel=1 at edge t2; done pulses exactly 18 cycles after acceptance (SETTLE_CYC=16).
- sel=1, request req_sel=1 -> done on the next cycle; busy stays 0; sel stays 1.
- Request req_sel=1 with clk1_ok_async held low -> err pulses after 1024 CHECK cycles; sel stays 0; req_ready returns high.
- clk1_ok rises 50 cycles into CHECK -> SWITCH 2–3 cycles after the rise; completion proceeds normally.
- req_valid toggled during SETTLE -> ignored; exactly one done pulse.
- rst_n pulsed low mid-SETTLE -> sel=0 at once; no done; next request completes normally.
